pru_port_if_mc: RTL and testbench
=================================

PRU_PORT_IF_MC -- requirements
Module: pru_port_if_mc

Interface
REQ-001 Parameter PW, default 128, packet width in bits.
REQ-002 Parameter NP, default 4, number of independent ports (>=1).
REQ-003 Parameter DEPTH, default 4, ingress buffer entries per port (power of 2, >=2); AW = clog2(DEPTH+1).
REQ-004 iClk  in  1  single clock; all state on rising edge.
REQ-005 iRst  in  1  reset, asynchronous, active-high.
REQ-006 iPort_vld  in  NP  device-to-block packet valid, per port.
REQ-007 iPort_pkt  in  NP*PW  device packets; port k at bits [k*PW +: PW] (applies to all packed buses).
REQ-008 oPort_ack  out  NP  one-cycle capture acknowledge to device.
REQ-009 oPort_vld  out  NP  block-to-device packet valid.
REQ-010 oPort_pkt  out  NP*PW  block-to-device packets.
REQ-011 iPort_ack  in  NP  device accepts oPort_pkt.
REQ-012 portIf_arbIn_vld  out  NP  ingress buffer non-empty, head presented to arbIn.
REQ-013 portIf_arbIn_pkt  out  NP*PW  ingress buffer head packet.
REQ-014 arbIn_portIf_ack  in  NP  arbIn takes head this cycle.
REQ-015 arbOut_portIf_vld  in  NP  arbOut offers egress packet.
REQ-016 arbOut_portIf_pkt  in  NP*PW  egress packet from arbOut.
REQ-017 portIf_arbOut_ack  out  NP  egress holding register empty/ready.
REQ-018 oPort_lvl  out  NP*AW  per-port ingress occupancy, 0..DEPTH.

Function
REQ-019 Each port SHALL be fully independent; no cross-port state or ordering.
REQ-020 Ingress capture for port k SHALL occur at a clock edge where iPort_vld[k]=1, oPort_ack[k]=0 and lvl[k]<DEPTH.
REQ-021 oPort_ack[k] SHALL be a register, 1 for exactly the cycle after a capture, else 0; max one capture per 2 cycles per port.
REQ-022 Full state (lvl=DEPTH) SHALL block capture even when a pop occurs on the same edge; vld is held, no packet lost.
REQ-023 Ingress buffer SHALL be FIFO, DEPTH entries, read/write pointers wrap modulo DEPTH.
REQ-024 portIf_arbIn_vld[k] SHALL equal (lvl[k]!=0); portIf_arbIn_pkt[k] SHALL be the oldest entry, combinational from storage; don't-care when empty.
REQ-025 Pop SHALL occur at an edge where portIf_arbIn_vld[k]=1 and arbIn_portIf_ack[k]=1; ack while empty SHALL be ignored.
REQ-026 Simultaneous push and pop SHALL leave lvl unchanged; push only +1; pop only -1.
REQ-027 Capture-to-arbIn latency SHALL be 1 cycle: packet captured at edge t is visible on portIf_arbIn_pkt in cycle after t when buffer was empty.
REQ-028 Egress: portIf_arbOut_ack[k] SHALL equal ~oPort_vld[k]; load at edge where arbOut_portIf_vld[k]=1 and portIf_arbOut_ack[k]=1.
REQ-029 After load, oPort_vld[k]=1 and oPort_pkt[k] SHALL hold stable until an edge with iPort_ack[k]=1, then oPort_vld[k]=0 next cycle.
REQ-030 iPort_ack[k] while oPort_vld[k]=0 SHALL be ignored; reload cannot occur on the same edge as release (one idle cycle minimum).
REQ-031 oPort_lvl SHALL be registered and reflect occupancy after the latest edge.

Reset
REQ-032 iRst=1 SHALL asynchronously clear pointers, lvl, oPort_ack, oPort_vld to 0; oPort_pkt to 0; buffer contents need not be cleared.
REQ-033 Reset mid-transfer SHALL discard all buffered and held packets; after release, portIf_arbOut_ack=all-ones and capture resumes on first edge.

Verification
REQ-034 Reset, NP=4: iPort_vld[0]=1 pkt=0xA5 -> oPort_ack[0]=1 one cycle, next cycle portIf_arbIn_vld[0]=1 pkt=0xA5, lvl[0]=1.
REQ-035 Fill port 2 with DEPTH=4 packets 1..4, arbIn ack held 0 -> lvl[2]=4, 5th vld held with no oPort_ack; then ack=1 pops 1,2,3,4 in order, 5th captured only after lvl<4.
REQ-036 lvl[1]=2, push and pop on same edge -> lvl[1] stays 2; 10 wrap-around pushes/pops keep order.
REQ-037 arbOut vld=1 pkt=0x3C on port 3 -> oPort_vld[3]=1 next cycle, portIf_arbOut_ack[3]=0; iPort_ack[3] delayed 5 cycles -> pkt stable, vld drops cycle after ack.
REQ-038 Assert iRst with lvl[0]=3 and oPort_vld[1]=1 -> all outputs 0 immediately (before next edge), arbOut ack all 1 after release.

Source files
------------

// File: rtl/pru_port_if_mc_if.sv
// Bundled handshake/data buses between the port interface block, the devices
// and the arbiters. Port k of any packed bus occupies [k*W +: W].
interface pru_port_if_mc_if #(
  parameter int PW    = 128,
  parameter int NP    = 4,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH + 1);

  // Device ingress
  logic [NP-1:0]    iPort_vld;
  logic [NP*PW-1:0] iPort_pkt;
  logic [NP-1:0]    oPort_ack;

  // Device egress
  logic [NP-1:0]    oPort_vld;
  logic [NP*PW-1:0] oPort_pkt;
  logic [NP-1:0]    iPort_ack;

  // Arbiter input side
  logic [NP-1:0]    portIf_arbIn_vld;
  logic [NP*PW-1:0] portIf_arbIn_pkt;
  logic [NP-1:0]    arbIn_portIf_ack;

  // Arbiter output side
  logic [NP-1:0]    arbOut_portIf_vld;
  logic [NP*PW-1:0] arbOut_portIf_pkt;
  logic [NP-1:0]    portIf_arbOut_ack;

  // Ingress occupancy
  logic [NP*AW-1:0] oPort_lvl;

  modport slave (
    input  iPort_vld, iPort_pkt, iPort_ack, arbIn_portIf_ack,
           arbOut_portIf_vld, arbOut_portIf_pkt,
    output oPort_ack, oPort_vld, oPort_pkt, portIf_arbIn_vld,
           portIf_arbIn_pkt, portIf_arbOut_ack, oPort_lvl
  );

  modport master (
    output iPort_vld, iPort_pkt, iPort_ack, arbIn_portIf_ack,
           arbOut_portIf_vld, arbOut_portIf_pkt,
    input  oPort_ack, oPort_vld, oPort_pkt, portIf_arbIn_vld,
           portIf_arbIn_pkt, portIf_arbOut_ack, oPort_lvl
  );
endinterface

// File: rtl/pru_port_if_mc.sv
// Per-port device interface: an ingress FIFO feeding arbIn and a one-entry
// egress holding register fed by arbOut. Ports share no state.
module pru_port_if_mc #(
  parameter int PW    = 128,
  parameter int NP    = 4,
  parameter int DEPTH = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  pru_port_if_mc_if.slave   bus
);
  localparam int AW   = $clog2(DEPTH + 1);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  for (genvar gi = 0; gi < NP; gi++) begin : g_port
    logic [PW-1:0]   mem_q [DEPTH];
    logic [PTRW-1:0] wptr_q;
    logic [PTRW-1:0] rptr_q;
    logic [AW-1:0]   lvl_q;
    logic [AW-1:0]   lvl_d;
    logic            ack_q;
    logic            ovld_q;
    logic [PW-1:0]   opkt_q;
    logic            push;
    logic            pop;
    logic            load;
    logic            rel;

    // Full blocks capture even if a pop lands on the same edge.
    assign push = bus.iPort_vld[gi] & ~ack_q & (lvl_q != AW'(DEPTH));
    assign pop  = (lvl_q != '0) & bus.arbIn_portIf_ack[gi];
    assign load = bus.arbOut_portIf_vld[gi] & ~ovld_q;
    assign rel  = ovld_q & bus.iPort_ack[gi];

    always_comb begin
      lvl_d = lvl_q;
      if (push && !pop) begin
        lvl_d = lvl_q + AW'(1);
      end else if (pop && !push) begin
        lvl_d = lvl_q - AW'(1);
      end
    end

    // Storage has no reset so it can map onto RAM resources.
    always_ff @(posedge iClk) begin
      if (push) begin
        mem_q[wptr_q] <= bus.iPort_pkt[gi*PW +: PW];
      end
    end

    always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        lvl_q  <= '0;
        ack_q  <= 1'b0;
      end else begin
        ack_q <= push;
        lvl_q <= lvl_d;
        if (push) begin
          wptr_q <= wptr_q + PTRW'(1);
        end
        if (pop) begin
          rptr_q <= rptr_q + PTRW'(1);
        end
      end
    end

    // Release and reload are exclusive since load requires ovld_q=0.
    always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
        ovld_q <= 1'b0;
        opkt_q <= '0;
      end else if (load) begin
        ovld_q <= 1'b1;
        opkt_q <= bus.arbOut_portIf_pkt[gi*PW +: PW];
      end else if (rel) begin
        ovld_q <= 1'b0;
      end
    end

    assign bus.oPort_ack[gi]                = ack_q;
    assign bus.oPort_vld[gi]                = ovld_q;
    assign bus.oPort_pkt[gi*PW +: PW]       = opkt_q;
    assign bus.portIf_arbIn_vld[gi]         = (lvl_q != '0);
    assign bus.portIf_arbIn_pkt[gi*PW +: PW] = mem_q[rptr_q];
    assign bus.portIf_arbOut_ack[gi]        = ~ovld_q;
    assign bus.oPort_lvl[gi*AW +: AW]       = lvl_q;
  end
endmodule

// File: tb/tb_pru_port_if_mc.sv
// Directed bench: stimulus pushes expected packets into per-port queues and a
// negedge monitor checks every arbIn pop and every device egress handoff.
module tb_pru_port_if_mc;
  localparam int PW    = 128;
  localparam int NP    = 4;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pru_port_if_mc_if #(.PW(PW), .NP(NP), .DEPTH(DEPTH)) bus ();

  pru_port_if_mc #(.PW(PW), .NP(NP), .DEPTH(DEPTH)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  logic [PW-1:0] exp_in  [NP][$];
  logic [PW-1:0] exp_out [NP][$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: values seen at negedge are what the next rising edge acts on.
  always @(negedge clk) begin : monitor
    logic [PW-1:0] e;
    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        if (bus.portIf_arbIn_vld[p] && bus.arbIn_portIf_ack[p]) begin
          $display("arbIn pop   port %0d pkt %0h", p, bus.portIf_arbIn_pkt[p*PW +: PW]);
          if (exp_in[p].size() == 0) begin
            chk($sformatf("arbin_unexpected_p%0d", p), PW'(1), PW'(0));
          end else begin
            e = exp_in[p].pop_front();
            chk($sformatf("arbin_pkt_p%0d", p), bus.portIf_arbIn_pkt[p*PW +: PW], e);
          end
        end
        if (bus.oPort_vld[p] && bus.iPort_ack[p]) begin
          $display("egress take port %0d pkt %0h", p, bus.oPort_pkt[p*PW +: PW]);
          if (exp_out[p].size() == 0) begin
            chk($sformatf("egress_unexpected_p%0d", p), PW'(1), PW'(0));
          end else begin
            e = exp_out[p].pop_front();
            chk($sformatf("egress_pkt_p%0d", p), bus.oPort_pkt[p*PW +: PW], e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lvl_chk(input string name, input int p, input int exp);
    chk(name, PW'(bus.oPort_lvl[p*AW +: AW]), PW'(exp));
  endtask

  // Offer one device packet and hold vld until the capture acknowledge.
  task automatic send(input int p, input logic [PW-1:0] v);
    bus.iPort_vld[p] = 1'b1;
    bus.iPort_pkt[p*PW +: PW] = v;
    exp_in[p].push_back(v);
    for (int i = 0; i < 64; i++) begin
      tick();
      if (bus.oPort_ack[p]) break;
    end
    if (!bus.oPort_ack[p]) chk("send_timeout", PW'(0), PW'(1));
    bus.iPort_vld[p] = 1'b0;
  endtask

  task automatic drain(input int p);
    bus.arbIn_portIf_ack[p] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (bus.oPort_lvl[p*AW +: AW] == '0) break;
    end
    bus.arbIn_portIf_ack[p] = 1'b0;
    chk($sformatf("drain_left_p%0d", p), PW'(exp_in[p].size()), PW'(0));
  endtask

  task automatic reset_outputs_chk(input string tag);
    chk({tag, "_oack"}, PW'(bus.oPort_ack), PW'(0));
    chk({tag, "_ovld"}, PW'(bus.oPort_vld), PW'(0));
    chk({tag, "_opkt"}, PW'(bus.oPort_pkt != '0), PW'(0));
    chk({tag, "_arbin_vld"}, PW'(bus.portIf_arbIn_vld), PW'(0));
    chk({tag, "_lvl"}, PW'(bus.oPort_lvl), PW'(0));
    chk({tag, "_arbout_ack"}, PW'(bus.portIf_arbOut_ack), PW'(4'hF));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.iPort_vld = '0;
    bus.iPort_pkt = '0;
    bus.iPort_ack = '0;
    bus.arbIn_portIf_ack = '0;
    bus.arbOut_portIf_vld = '0;
    bus.arbOut_portIf_pkt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_outputs_chk("reset");
    rst = 1'b0;

    // Single capture on port 0: ack and arbIn head in the cycle after capture.
    tick();
    bus.iPort_vld[0] = 1'b1;
    bus.iPort_pkt[0 +: PW] = PW'('hA5);
    exp_in[0].push_back(PW'('hA5));
    tick();
    bus.iPort_vld[0] = 1'b0;
    @(negedge clk);
    chk("cap_oack", PW'(bus.oPort_ack), PW'(4'b0001));
    chk("cap_arbin_vld", PW'(bus.portIf_arbIn_vld), PW'(4'b0001));
    chk("cap_arbin_pkt", bus.portIf_arbIn_pkt[0 +: PW], PW'('hA5));
    lvl_chk("cap_lvl0", 0, 1);
    tick();
    @(negedge clk);
    chk("cap_oack_one_cycle", PW'(bus.oPort_ack), PW'(0));
    drain(0);
    // Ack while empty must not underflow.
    bus.arbIn_portIf_ack[0] = 1'b1;
    tick();
    bus.arbIn_portIf_ack[0] = 1'b0;
    @(negedge clk);
    lvl_chk("empty_ack_lvl0", 0, 0);
    chk("empty_ack_vld", PW'(bus.portIf_arbIn_vld[0]), PW'(0));

    // Fill port 2, fifth packet must wait for room.
    for (int i = 1; i <= 4; i++) send(2, PW'(i));
    @(negedge clk);
    lvl_chk("full_lvl2", 2, 4);
    bus.iPort_vld[2] = 1'b1;
    bus.iPort_pkt[2*PW +: PW] = PW'(5);
    exp_in[2].push_back(PW'(5));
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("full_no_ack", PW'(bus.oPort_ack[2]), PW'(0));
      lvl_chk("full_hold_lvl2", 2, 4);
    end
    bus.arbIn_portIf_ack[2] = 1'b1;
    tick();
    chk("full_pop_no_capture", PW'(bus.oPort_ack[2]), PW'(0));
    lvl_chk("full_pop_lvl2", 2, 3);
    for (int i = 0; i < 32; i++) begin
      if (bus.oPort_ack[2]) bus.iPort_vld[2] = 1'b0;
      if (bus.oPort_lvl[2*AW +: AW] == '0 && !bus.iPort_vld[2]) break;
      tick();
    end
    bus.arbIn_portIf_ack[2] = 1'b0;
    chk("full_drain_left", PW'(exp_in[2].size()), PW'(0));

    // Port 1: simultaneous push/pop at level 2, then wrap the pointers.
    send(1, PW'('h11));
    send(1, PW'('h22));
    @(negedge clk);
    lvl_chk("pp_lvl1_start", 1, 2);
    for (int i = 0; i < 11; i++) begin
      tick();
      bus.iPort_vld[1] = 1'b1;
      bus.iPort_pkt[1*PW +: PW] = PW'('h100 + i);
      exp_in[1].push_back(PW'('h100 + i));
      bus.arbIn_portIf_ack[1] = 1'b1;
      tick();
      bus.iPort_vld[1] = 1'b0;
      bus.arbIn_portIf_ack[1] = 1'b0;
      @(negedge clk);
      lvl_chk("pp_lvl1", 1, 2);
      chk("pp_oack1", PW'(bus.oPort_ack[1]), PW'(1));
    end
    drain(1);

    // Port 3 egress: hold under delayed ack, then no reload on release edge.
    tick();
    bus.arbOut_portIf_vld[3] = 1'b1;
    bus.arbOut_portIf_pkt[3*PW +: PW] = PW'('h3C);
    exp_out[3].push_back(PW'('h3C));
    tick();
    bus.arbOut_portIf_vld[3] = 1'b0;
    @(negedge clk);
    chk("eg_vld3", PW'(bus.oPort_vld[3]), PW'(1));
    chk("eg_arbout_ack3", PW'(bus.portIf_arbOut_ack[3]), PW'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("eg_hold_pkt3", bus.oPort_pkt[3*PW +: PW], PW'('h3C));
      chk("eg_hold_vld3", PW'(bus.oPort_vld[3]), PW'(1));
    end
    tick();
    bus.iPort_ack[3] = 1'b1;
    bus.arbOut_portIf_vld[3] = 1'b1;
    bus.arbOut_portIf_pkt[3*PW +: PW] = PW'('h5A);
    exp_out[3].push_back(PW'('h5A));
    tick();
    bus.iPort_ack[3] = 1'b0;
    @(negedge clk);
    chk("eg_released_vld3", PW'(bus.oPort_vld[3]), PW'(0));
    chk("eg_released_ack3", PW'(bus.portIf_arbOut_ack[3]), PW'(1));
    tick();
    bus.arbOut_portIf_vld[3] = 1'b0;
    @(negedge clk);
    chk("eg_reload_vld3", PW'(bus.oPort_vld[3]), PW'(1));
    chk("eg_reload_pkt3", bus.oPort_pkt[3*PW +: PW], PW'('h5A));
    tick();
    bus.iPort_ack[3] = 1'b1;
    tick();
    bus.iPort_ack[3] = 1'b0;
    @(negedge clk);
    chk("eg_final_vld3", PW'(bus.oPort_vld[3]), PW'(0));
    chk("eg_left3", PW'(exp_out[3].size()), PW'(0));

    // Reset with data buffered on port 0 and held on port 1.
    send(0, PW'(1));
    send(0, PW'(2));
    send(0, PW'(3));
    tick();
    bus.arbOut_portIf_vld[1] = 1'b1;
    bus.arbOut_portIf_pkt[1*PW +: PW] = PW'('h77);
    tick();
    bus.arbOut_portIf_vld[1] = 1'b0;
    @(negedge clk);
    lvl_chk("pre_rst_lvl0", 0, 3);
    chk("pre_rst_ovld1", PW'(bus.oPort_vld[1]), PW'(1));
    #1 rst = 1'b1;
    exp_in[0].delete();
    exp_out[1].delete();
    #1;
    reset_outputs_chk("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_arbout_ack", PW'(bus.portIf_arbOut_ack), PW'(4'hF));
    lvl_chk("post_rst_lvl0", 0, 0);
    tick();
    bus.iPort_vld[0] = 1'b1;
    bus.iPort_pkt[0 +: PW] = PW'('hBEEF);
    exp_in[0].push_back(PW'('hBEEF));
    tick();
    chk("resume_first_edge", PW'(bus.oPort_ack[0]), PW'(1));
    bus.iPort_vld[0] = 1'b0;
    drain(0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
